// File: rtl/adc_cfg_pkg.sv
// Shared types and constants for the ADS5292 configuration serial writer.
package adc_cfg_pkg;

    localparam int unsigned WORD_W   = 24;
    localparam logic        SEN_IDLE = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StLoad,
        StShift,
        StGap,
        StNext,
        StFin
    } state_e;

    // Counter width for a modulus of n; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_cfg_sclk_gen.sv
// SCLK divider: low then high for CLK_DIV cycles each while enabled, idle low otherwise.
module adc_cfg_sclk_gen
    import adc_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned          DivW    = cnt_w(CLK_DIV);
    localparam logic [DivW-1:0]      DivLast = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_q;
    logic            sclk_q;
    logic            wrap;

    assign wrap = en_i && (div_q == DivLast);

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else if (wrap) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            div_q  <= div_q + 1'b1;
        end
    end

    // Strobes flag the edge on which sclk is about to change.
    assign rise_o = wrap & ~sclk_q;
    assign fall_o = wrap & sclk_q;
    assign sclk_o = sclk_q;

endmodule

// File: rtl/adc_cfg_spi_writer.sv
// Serialises 24-bit ADS5292 config words onto SEN/SCLK/SDATA, either as a single write
// or by stepping the upstream register unit through its auto-config list.
module adc_cfg_spi_writer
    import adc_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned GAP_CYC   = 4,
    parameter int unsigned MAX_WORDS = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_auto_i,
    input  logic              wr_req_i,
    input  logic [WORD_W-1:0] reg_in_i,
    input  logic              end_auto_i,
    output logic              init_reg_o,
    output logic              incr_reg_o,
    output logic              auto_run_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              adc_sen_o,
    output logic              adc_sclk_o,
    output logic              adc_sdata_o
);

    localparam int unsigned     GapW    = cnt_w(GAP_CYC);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYC - 1);
    localparam logic [3:0]      WordMax = 4'(MAX_WORDS);

    state_e            state_q;
    logic [WORD_W-1:0] shift_q;
    logic [4:0]        bit_cnt_q;
    logic [GapW-1:0]   gap_cnt_q;
    logic [3:0]        word_cnt_q;
    logic              last_q;
    logic              init_reg_q, incr_reg_q, auto_run_q, busy_q, done_q, err_q;
    logic              sen_q, sdata_q;

    logic sclk, sclk_rise, sclk_fall;
    logic unused_rise;

    adc_cfg_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (state_q == StShift),
        .sclk_o (sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // Data moves only on the falling transition, so the rise strobe is not needed here.
    assign unused_rise = sclk_rise;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            word_cnt_q <= '0;
            last_q     <= 1'b0;
            init_reg_q <= 1'b0;
            incr_reg_q <= 1'b0;
            auto_run_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            sen_q      <= SEN_IDLE;
            sdata_q    <= 1'b0;
        end else begin
            init_reg_q <= 1'b0;
            incr_reg_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_auto_i) begin
                        state_q    <= StInit;
                        auto_run_q <= 1'b1;
                        busy_q     <= 1'b1;
                        init_reg_q <= 1'b1;
                    end else if (wr_req_i) begin
                        state_q    <= StLoad;
                        busy_q     <= 1'b1;
                    end
                end
                StInit: state_q <= StLoad;
                StLoad: begin
                    shift_q   <= reg_in_i;
                    sdata_q   <= reg_in_i[WORD_W-1];
                    sen_q     <= ~SEN_IDLE;
                    last_q    <= auto_run_q ? end_auto_i : 1'b1;
                    bit_cnt_q <= '0;
                    if (word_cnt_q != WordMax) begin
                        word_cnt_q <= word_cnt_q + 1'b1;
                    end
                    state_q   <= StShift;
                end
                StShift: begin
                    if (sclk_fall) begin
                        if (bit_cnt_q == 5'(WORD_W - 1)) begin
                            sen_q     <= SEN_IDLE;
                            sdata_q   <= 1'b0;
                            gap_cnt_q <= '0;
                            state_q   <= StGap;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            shift_q   <= shift_q << 1;
                            sdata_q   <= shift_q[WORD_W-2];
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        if (last_q) begin
                            state_q    <= StFin;
                            done_q     <= 1'b1;
                        end else if (word_cnt_q == WordMax) begin
                            // Runaway list: abort without a done pulse.
                            state_q    <= StIdle;
                            err_q      <= 1'b1;
                            auto_run_q <= 1'b0;
                            busy_q     <= 1'b0;
                            word_cnt_q <= '0;
                        end else begin
                            state_q    <= StNext;
                            incr_reg_q <= 1'b1;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                StNext: state_q <= StLoad;
                StFin: begin
                    state_q    <= StIdle;
                    auto_run_q <= 1'b0;
                    busy_q     <= 1'b0;
                    word_cnt_q <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign init_reg_o  = init_reg_q;
    assign incr_reg_o  = incr_reg_q;
    assign auto_run_o  = auto_run_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign adc_sen_o   = sen_q;
    assign adc_sclk_o  = sclk;
    assign adc_sdata_o = sdata_q;

endmodule

// File: tb/tb_adc_cfg_spi_writer.sv
// Bench for adc_cfg_spi_writer: a timeline model derived from word/bit arithmetic is compared
// against both a slow (CLK_DIV=4) and a fast (CLK_DIV=1) instance every cycle.
module tb_adc_cfg_spi_writer;

    localparam int D0 = 4, G0 = 4, D1 = 1, G1 = 1, MAXW = 8;

    typedef struct packed {
        logic init_reg, incr_reg, auto_run, busy, done, err, sen, sclk, sdata;
    } outs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] start_auto = '0, wr_req = '0, end_auto;
    logic [23:0] reg_in0, reg_in1;
    wire  [1:0] init_reg, incr_reg, auto_run, busy, done, err, sen, sclk, sdata;

    // Register-unit stand-in: table indexed by a counter that init_reg/incr_reg move.
    logic [23:0] tbl [16];
    logic [3:0]  cnt [2];
    int          end_at;

    // Model state per instance.
    bit          job_act [2];
    bit          job_auto[2];
    bit          job_err [2];
    int          job_start[2], job_nw[2], job_nend[2], job_acc[2];
    logic [23:0] job_words[2][8];

    int cyc = 0, n_cmp = 0, n_bad = 0;
    bit chk_en = 1'b0;

    // Monitor (watches instance mon_i).
    int          mon_i = 0;
    logic [23:0] acc;
    logic [23:0] mon_words[$];
    int          mon_lens[$];
    int          sen_low, nbits, c_init, c_incr, c_done, c_err;
    logic        prev_sclk = 1'b0, prev_sen = 1'b1;

    assign reg_in0 = tbl[cnt[0]];
    assign reg_in1 = tbl[cnt[1]];
    assign end_auto[0] = (end_at != 0) && (int'(cnt[0]) == end_at);
    assign end_auto[1] = (end_at != 0) && (int'(cnt[1]) == end_at);

    adc_cfg_spi_writer #(.CLK_DIV(D0), .GAP_CYC(G0), .MAX_WORDS(MAXW)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_auto_i(start_auto[0]), .wr_req_i(wr_req[0]),
        .reg_in_i(reg_in0), .end_auto_i(end_auto[0]), .init_reg_o(init_reg[0]),
        .incr_reg_o(incr_reg[0]), .auto_run_o(auto_run[0]), .busy_o(busy[0]), .done_o(done[0]),
        .err_o(err[0]), .adc_sen_o(sen[0]), .adc_sclk_o(sclk[0]), .adc_sdata_o(sdata[0])
    );

    adc_cfg_spi_writer #(.CLK_DIV(D1), .GAP_CYC(G1), .MAX_WORDS(MAXW)) u_fast (
        .clk_i(clk), .rst_i(rst), .start_auto_i(start_auto[1]), .wr_req_i(wr_req[1]),
        .reg_in_i(reg_in1), .end_auto_i(end_auto[1]), .init_reg_o(init_reg[1]),
        .incr_reg_o(incr_reg[1]), .auto_run_o(auto_run[1]), .busy_o(busy[1]), .done_o(done[1]),
        .err_o(err[1]), .adc_sen_o(sen[1]), .adc_sclk_o(sclk[1]), .adc_sdata_o(sdata[1])
    );

    initial forever #5 clk = ~clk;

    function automatic outs_t got_outs(input int i);
        return '{init_reg: init_reg[i], incr_reg: incr_reg[i], auto_run: auto_run[i],
                 busy: busy[i], done: done[i], err: err[i], sen: sen[i], sclk: sclk[i],
                 sdata: sdata[i]};
    endfunction

    // Expected outputs after edge e: word j occupies a window of 2+48D+G cycles
    // (load, 24 bits of 2D cycles, gap, then next/fin/abort).
    function automatic outs_t exp_outs(input int i, input int e);
        outs_t       o;
        int          n, base, w, j, k, s, d, g;
        logic [23:0] wv;
        o = '0;
        o.sen = 1'b1;
        if (!job_act[i]) return o;
        n = e - job_start[i];
        if (n > job_nend[i]) return o;
        d = (i == 0) ? D0 : D1;
        g = (i == 0) ? G0 : G1;
        w = 2 + 48 * d + g;
        o.busy = 1'b1;
        o.auto_run = job_auto[i];
        if (job_auto[i] && n == 0) begin
            o.init_reg = 1'b1;
            return o;
        end
        base = job_auto[i] ? 1 : 0;
        j = (n - base) / w;
        k = (n - base) % w;
        if (k >= 1 && k <= 48 * d) begin
            s = k - 1;
            wv = job_words[i][j];
            o.sen = 1'b0;
            o.sclk = (s % (2 * d)) >= d;
            o.sdata = wv[23 - s / (2 * d)];
        end else if (k == w - 1) begin
            if (j < job_nw[i] - 1) o.incr_reg = 1'b1;
            else if (job_err[i]) begin
                o.busy = 1'b0;
                o.auto_run = 1'b0;
                o.err = 1'b1;
            end else o.done = 1'b1;
        end
        return o;
    endfunction

    task automatic start_job(input int i, input bit is_auto);
        int d, g, w, base, last_busy;
        d = (i == 0) ? D0 : D1;
        g = (i == 0) ? G0 : G1;
        w = 2 + 48 * d + g;
        job_act[i] = 1'b1;
        job_start[i] = cyc;
        job_auto[i] = is_auto;
        if (is_auto) begin
            job_err[i] = !(end_at >= 1 && end_at <= MAXW);
            job_nw[i] = job_err[i] ? MAXW : end_at;
            for (int j = 0; j < MAXW; j++) job_words[i][j] = tbl[j + 1];
        end else begin
            job_err[i] = 1'b0;
            job_nw[i] = 1;
            job_words[i][0] = tbl[cnt[i]];
        end
        base = is_auto ? 1 : 0;
        job_nend[i] = base + job_nw[i] * w - 1;
        last_busy = job_err[i] ? job_nend[i] - 1 : job_nend[i];
        job_acc[i] = cyc + last_busy + 2;
    endtask

    // Edge process: request acceptance by the model and the register-unit counter.
    initial begin
        cnt[0] = '0;
        cnt[1] = '0;
        job_act[0] = 1'b0;
        job_act[1] = 1'b0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            for (int i = 0; i < 2; i++) begin
                if (rst) job_act[i] = 1'b0;
                else if ((start_auto[i] || wr_req[i]) && (!job_act[i] || cyc >= job_acc[i]))
                    start_job(i, start_auto[i]);
                if (init_reg[i]) cnt[i] <= 4'd1;
                else if (incr_reg[i]) cnt[i] <= cnt[i] + 4'd1;
            end
        end
    end

    // Compare process plus monitor, sampled mid-cycle.
    initial begin
        outs_t gv, xv;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 2; i++) begin
                    gv = got_outs(i);
                    xv = exp_outs(i, cyc);
                    n_cmp++;
                    if (gv !== xv) begin
                        n_bad++;
                        $display("FAIL cycle_model inst=%0d cyc=%0d got=%b expected=%b", i, cyc,
                                 gv, xv);
                    end
                end
            end
            gv = got_outs(mon_i);
            if (gv.sclk && !prev_sclk) begin
                acc = {acc[22:0], gv.sdata};
                nbits++;
            end
            if (!gv.sen) sen_low++;
            if (gv.sen && !prev_sen) begin
                mon_words.push_back(acc);
                mon_lens.push_back(sen_low);
                sen_low = 0;
            end
            prev_sclk = gv.sclk;
            prev_sen = gv.sen;
            c_init += int'(gv.init_reg);
            c_incr += int'(gv.incr_reg);
            c_done += int'(gv.done);
            c_err  += int'(gv.err);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic mon_clear(input int i);
        mon_i = i;
        mon_words.delete();
        mon_lens.delete();
        sen_low = 0;
        nbits = 0;
        c_init = 0;
        c_incr = 0;
        c_done = 0;
        c_err = 0;
    endtask

    task automatic pulse(input int i, input bit sa, input bit wr);
        @(posedge clk);
        #1;
        start_auto[i] = sa;
        wr_req[i] = wr;
        @(posedge clk);
        #1;
        start_auto[i] = 1'b0;
        wr_req[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int budget);
        int k;
        k = 0;
        while (job_act[i] && cyc < job_acc[i] && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle inst=%0d: still busy after %0d cycles, expected idle", i, k);
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic int word_at(input int j);
        return (mon_words.size() > j) ? int'(mon_words[j]) : -1;
    endfunction

    initial begin
        logic [23:0] stuck_words[8];
        for (int j = 0; j < 16; j++) tbl[j] = 24'($urandom);
        end_at = 3;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_idle_slow", {sen[0], sclk[0], sdata[0], busy[0], auto_run[0]}, 5'b10000);
        chk("reset_idle_fast", {sen[1], sclk[1], sdata[1], busy[1], auto_run[1]}, 5'b10000);

        // Single write at CLK_DIV=4.
        mon_clear(0);
        tbl[cnt[0]] = 24'h26AA80;
        pulse(0, 1'b0, 1'b1);
        wait_idle(0, 1000);
        chk("single_nwords", mon_words.size(), 1);
        chk("single_word", word_at(0), 24'h26AA80);
        chk("single_sen_low", (mon_lens.size() > 0) ? mon_lens[0] : -1, 192);
        chk("single_done", c_done, 1);
        chk("single_init_incr", c_init + c_incr, 0);

        // Auto sequence of three words.
        mon_clear(0);
        tbl[1] = 24'h26AA80;
        tbl[2] = 24'h275540;
        tbl[3] = 24'h450001;
        end_at = 3;
        pulse(0, 1'b1, 1'b0);
        wait_idle(0, 2000);
        chk("auto_nwords", mon_words.size(), 3);
        chk("auto_word0", word_at(0), 24'h26AA80);
        chk("auto_word1", word_at(1), 24'h275540);
        chk("auto_word2", word_at(2), 24'h450001);
        chk("auto_init", c_init, 1);
        chk("auto_incr", c_incr, 2);
        chk("auto_done", c_done, 1);
        chk("auto_run_after", auto_run[0], 0);

        // Collision, then ignored requests mid-sequence.
        mon_clear(0);
        pulse(0, 1'b1, 1'b1);
        repeat (300) @(posedge clk);
        pulse(0, 1'b0, 1'b1);
        repeat (100) @(posedge clk);
        pulse(0, 1'b1, 1'b0);
        wait_idle(0, 2000);
        chk("collide_nwords", mon_words.size(), 3);
        chk("collide_word0", word_at(0), 24'h26AA80);
        chk("collide_init_incr", c_init * 16 + c_incr, 16 + 2);
        chk("collide_done", c_done, 1);

        // end_auto stuck low: abort after MAX_WORDS words.
        mon_clear(0);
        end_at = 0;
        for (int j = 0; j < 8; j++) stuck_words[j] = tbl[j + 1];
        pulse(0, 1'b1, 1'b0);
        wait_idle(0, 3000);
        chk("stuck_nwords", mon_words.size(), 8);
        chk("stuck_word7", word_at(7), int'(stuck_words[7]));
        chk("stuck_err", c_err, 1);
        chk("stuck_done", c_done, 0);
        chk("stuck_idle", {auto_run[0], busy[0]}, 2'b00);

        // Reset while shifting.
        mon_clear(0);
        pulse(0, 1'b0, 1'b1);
        repeat (60) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_lines", {sen[0], sclk[0], sdata[0], busy[0]}, 4'b1000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (300) @(posedge clk);
        chk("midreset_no_pulse", c_done + c_err, 0);

        // CLK_DIV=1, GAP_CYC=1 single write.
        mon_clear(1);
        tbl[cnt[1]] = 24'h450002;
        pulse(1, 1'b0, 1'b1);
        wait_idle(1, 500);
        chk("fast_word", word_at(0), 24'h450002);
        chk("fast_sen_low", (mon_lens.size() > 0) ? mon_lens[0] : -1, 48);
        chk("fast_rises", nbits, 24);
        chk("fast_done", c_done, 1);

        // Randomized jobs on both instances, including requests that land while busy.
        for (int it = 0; it < 18; it++) begin
            int i, kind;
            i = (it % 3 == 2) ? 1 : 0;
            mon_clear(i);
            for (int j = 0; j < 16; j++) tbl[j] = 24'($urandom);
            end_at = $urandom_range(0, 10);
            kind = $urandom_range(0, 2);
            pulse(i, kind != 0, kind != 1);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 400)) @(posedge clk);
                pulse(i, $urandom_range(0, 1) == 1, 1'b1);
            end
            wait_idle(i, 4000);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
